reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 83 ++++++++
 tb/tb_reg_file_mp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with x0 hardwired to zero and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge write data combinationally to matching read ports.
module reg_file_mp #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic [NUM_REGS-1:0]        busy,
  output logic [NUM_RD-1:0]          rd_busy
);

  logic [DATA_W-1:0]   mem    [NUM_REGS];
  logic [DATA_W-1:0]   wr_val [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // Ports are scanned in ascending order so the highest-numbered port wins a same-address conflict.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) wr_val[r] = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
        wr_hit[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
        wr_val[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // A same-edge alloc overrides the write's clear: the new producer still owes a result.
  always_comb begin
    busy_nxt = busy_q & ~wr_hit;
    if (alloc_en && (alloc_addr != '0)) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) mem[r] <= wr_val[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  always_comb begin : rd_mux
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra         = rd_addr[k*ADDR_W +: ADDR_W];
      rd_busy[k] = busy_q[ra];
      if (ra != '0) begin
`ifdef REGFILE_BYPASS_EN
        rd_data[k*DATA_W +: DATA_W] = wr_hit[ra] ? wr_val[ra] : mem[ra];
`else
        rd_data[k*DATA_W +: DATA_W] = mem[ra];
`endif
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and random checks of reg_file_mp (2 read, 2 write ports) against a reference model.
module tb_reg_file_mp;

  localparam int DW  = 64;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic              clk = 1'b0;
  logic              clk_run = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic [NR-1:0]     busy;
  logic [NRD-1:0]    rd_busy;

  reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy), .rd_busy(rd_busy)
  );

  always #5 if (clk_run) clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  logic [63:0] exp_q [$];
  logic [63:0] m_mem [NR];
  logic [NR-1:0] m_busy;

  task automatic push_exp(input logic [63:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    e = exp_q.pop_front();
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
  endtask

  task automatic chk_const(input string tag, input logic [63:0] obs, input logic [63:0] e);
    push_exp(e);
    chk(tag, obs);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_mem[r] = '0;
    m_busy = '0;
  endtask

  function automatic logic [63:0] exp_read(input logic [AW-1:0] ra);
    logic [63:0] v;
    v = (ra == '0) ? 64'd0 : m_mem[ra];
`ifdef REGFILE_BYPASS_EN
    if (ra != '0) begin
      if (wr_en[0] && wr_addr[AW-1:0] == ra) v = wr_data[DW-1:0];
      if (wr_en[1] && wr_addr[2*AW-1:AW] == ra) v = wr_data[2*DW-1:DW];
    end
`endif
    return v;
  endfunction

  task automatic model_edge();
    logic [NR-1:0] hit;
    logic [AW-1:0] a;
    hit = '0;
    for (int j = 0; j < NWR; j++) begin
      a = wr_addr[j*AW +: AW];
      if (wr_en[j] && a != '0) begin
        m_mem[a] = wr_data[j*DW +: DW];
        hit[a] = 1'b1;
      end
    end
    m_busy = m_busy & ~hit;
    if (alloc_en && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  // One clock: drive after negedge, check combinational outputs, then advance the model at posedge.
  task automatic step(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic [1:0] we,
                      input logic [AW-1:0] wa0, input logic [63:0] wd0,
                      input logic [AW-1:0] wa1, input logic [63:0] wd1,
                      input logic ae, input logic [AW-1:0] aa);
    @(negedge clk);
    rd_addr    = {ra1, ra0};
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    alloc_en   = ae;
    alloc_addr = aa;
    push_exp(exp_read(ra0));
    push_exp(exp_read(ra1));
    push_exp({62'd0, m_busy[ra1], m_busy[ra0]});
    push_exp({32'd0, m_busy});
    #1;
    chk("rd_data0", rd_data[DW-1:0]);
    chk("rd_data1", rd_data[2*DW-1:DW]);
    chk("rd_busy", {62'd0, rd_busy});
    chk("busy", {32'd0, busy});
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle_read(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    step(ra0, ra1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    rd_addr = {5'd5, 5'd3}; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk_const("rst_rd0", rd_data[DW-1:0], 64'd0);
    chk_const("rst_rd1", rd_data[2*DW-1:DW], 64'd0);
    chk_const("rst_busy", {32'd0, busy}, 64'd0);
    chk_const("rst_rd_busy", {62'd0, rd_busy}, 64'd0);

    #2 rst_n = 1'b1;
    clk_run = 1'b1;

    // First edge after release writes x5 and allocates x5.
    step(5'd5, 5'd0, 2'b01, 5'd5, 64'hDEAD, 5'd0, 64'd0, 1'b1, 5'd5);
    @(negedge clk);
    rd_addr = {5'd0, 5'd5}; wr_en = '0; alloc_en = 1'b0;
    #1;
    chk_const("pre_rst_x5", rd_data[DW-1:0], 64'hDEAD);
    chk_const("pre_rst_busy", {32'd0, busy}, 64'h20);
    rst_n = 1'b0;
    #1;
    chk_const("async_rst_x5", rd_data[DW-1:0], 64'd0);
    chk_const("async_rst_busy", {32'd0, busy}, 64'd0);
    chk_const("async_rst_rd_busy", {62'd0, rd_busy}, 64'd0);
    model_reset();
    // Write attempted while reset is held must be lost.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {64'd0, 64'h77};
    alloc_en = 1'b1; alloc_addr = 5'd6;
    @(posedge clk);
    @(negedge clk);
    wr_en = '0; alloc_en = 1'b0;
    rst_n = 1'b1;
    idle_read(5'd6, 5'd5);
    chk_const("rst_lost_x6", rd_data[DW-1:0], 64'd0);

    // Zero register ignores writes and allocs.
    step(5'd0, 5'd0, 2'b01, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'd0, 1'b1, 5'd0);
    idle_read(5'd0, 5'd0);
    chk_const("x0_zero", rd_data[DW-1:0], 64'd0);
    chk_const("x0_busy", {63'd0, busy[0]}, 64'd0);

    // Same-edge conflict: port 1 wins.
    step(5'd7, 5'd7, 2'b11, 5'd7, 64'h11, 5'd7, 64'h22, 1'b0, 5'd0);
    idle_read(5'd7, 5'd7);
    chk_const("conflict_p0", rd_data[DW-1:0], 64'h22);
    chk_const("conflict_p1", rd_data[2*DW-1:DW], 64'h22);

    // Distinct-address writes on one edge both commit.
    step(5'd0, 5'd0, 2'b11, 5'd10, 64'hA0, 5'd11, 64'hB1, 1'b0, 5'd0);
    idle_read(5'd10, 5'd11);
    chk_const("dual_x10", rd_data[DW-1:0], 64'hA0);
    chk_const("dual_x11", rd_data[2*DW-1:DW], 64'hB1);

    // Read-during-write on x3.
    step(5'd0, 5'd0, 2'b01, 5'd3, 64'h1, 5'd0, 64'd0, 1'b0, 5'd0);
    step(5'd3, 5'd0, 2'b01, 5'd3, 64'hABCD, 5'd0, 64'd0, 1'b0, 5'd0);
    idle_read(5'd3, 5'd3);
    chk_const("bypass_next", rd_data[DW-1:0], 64'hABCD);

    // Scoreboard: alloc, clear by write, alloc+write, re-alloc while busy.
    step(5'd0, 5'd0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd9);
    idle_read(5'd0, 5'd9);
    chk_const("alloc_busy9", {63'd0, busy[9]}, 64'd1);
    chk_const("alloc_rd_busy", {62'd0, rd_busy}, 64'd2);
    step(5'd9, 5'd9, 2'b01, 5'd9, 64'h5, 5'd0, 64'd0, 1'b0, 5'd0);
    idle_read(5'd9, 5'd0);
    chk_const("write_clr_busy9", {63'd0, busy[9]}, 64'd0);
    step(5'd0, 5'd0, 2'b10, 5'd0, 64'd0, 5'd9, 64'h5, 1'b1, 5'd9);
    idle_read(5'd9, 5'd0);
    chk_const("alloc_wr_data9", rd_data[DW-1:0], 64'h5);
    chk_const("alloc_wr_busy9", {63'd0, busy[9]}, 64'd1);
    step(5'd9, 5'd0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd9);
    idle_read(5'd9, 5'd9);
    chk_const("realloc_busy9", {63'd0, busy[9]}, 64'd1);

    // Random multi-port traffic, biased toward a few low registers to provoke collisions.
    for (int i = 0; i < 10000; i++) begin
      logic [AW-1:0] a [5];
      for (int n = 0; n < 5; n++)
        a[n] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      step(a[0], a[1], 2'($urandom), a[2], {$urandom, $urandom}, a[3], {$urandom, $urandom},
           1'($urandom_range(0, 2) == 0), a[4]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
